sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL take parameter ADDR_W, default 25, SDRAM word address width.
REQ-002 SHALL take parameter DATA_W, default 16, SDRAM data width.
REQ-003 SHALL take parameter BURST_LEN, default 8, max words accepted per grant.
REQ-004 SHALL take parameter MAX_OUTST, default 8, max read words in flight.
REQ-005 SHALL have port in_clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port in_reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports wr_req in 1, wr_addr in ADDR_W, wr_data in DATA_W, wr_ack out 1, which form the write requester (image loader) port.
REQ-008 SHALL have ports rd_req in 1, rd_addr in ADDR_W, rd_ack out 1, rd_data out DATA_W, rd_valid out 1, which form the read requester (VGA prefetch) port.
REQ-009 SHALL have ports mem_addr out ADDR_W, mem_write out 1, mem_read out 1, mem_writedata out DATA_W, mem_waitrequest in 1, mem_readdata in DATA_W, mem_readdatavalid in 1, which form the SDRAM controller port.
REQ-010 SHALL have status ports grant out 2 ({rd,wr} one-hot or zero) and busy out 1 (state != IDLE).

Function
REQ-011 SHALL implement states IDLE, WR_BURST, RD_BURST.
REQ-012 In IDLE with exactly one req high, SHALL enter that requester's BURST state next cycle.
REQ-013 In IDLE with both req high, SHALL grant the requester not granted last (round-robin via last_grant register).
REQ-014 Grant latency SHALL be one cycle: req seen in IDLE at edge N -> mem_write/mem_read visible after edge N.
REQ-015 In WR_BURST: mem_write = wr_req, mem_addr = wr_addr, mem_writedata = wr_data; combinational.
REQ-016 In RD_BURST: mem_read = rd_req AND (outst < MAX_OUTST), mem_addr = rd_addr; combinational.
REQ-017 A word is accepted when mem_write or mem_read is high and mem_waitrequest is low; wr_ack/rd_ack SHALL pulse high in exactly that cycle.
REQ-018 Requesters SHALL hold req, addr, data stable until ack; arbiter SHALL NOT latch addr/data.
REQ-019 burst_cnt SHALL increment per accepted word and clear on entering IDLE.
REQ-020 BURST state SHALL return to IDLE after the BURST_LEN-th accepted word, or after any cycle in which its req is low.
REQ-021 On leaving a BURST state, last_grant SHALL record that requester; every grant ends with at least one IDLE cycle.
REQ-022 Outside its BURST state a requester's mem strobe and ack SHALL be low.
REQ-023 outst counter (width clog2(MAX_OUTST)+1): +1 on accepted read, -1 on mem_readdatavalid, unchanged when both occur.
REQ-024 rd_data = mem_readdata and rd_valid = mem_readdatavalid, combinational in every state, including WR_BURST and IDLE.
REQ-025 At outst == MAX_OUTST, read issue SHALL stall; burst remains in RD_BURST while rd_req high.
REQ-026 mem_readdatavalid with outst == 0 SHALL be forwarded and counter SHALL saturate at 0.
REQ-027 mem_addr/mem_writedata SHALL be 0 in IDLE.

Reset
REQ-028 in_reset high SHALL asynchronously force state IDLE, burst_cnt 0, outst 0, last_grant = RD (write wins first tie).
REQ-029 Under reset, mem_write, mem_read, wr_ack, rd_ack, grant, busy SHALL be 0.
REQ-030 Reset asserted mid-burst SHALL abort the burst; unacked words are not retried; read data arriving later is forwarded per REQ-024.

Structure
REQ-031 Package sdram_arb_pkg SHALL hold state encoding, grant encodings, BURST_LEN and MAX_OUTST defaults.
REQ-032 Outstanding-read counter SHALL be sub-module sdram_rd_outst_cnt (inc, dec, full, count outputs).

Verification
REQ-033 wr_req held, waitrequest 0, BURST_LEN 8 -> 8 consecutive wr_ack, 1 IDLE cycle, next burst starts with next 8 wr_ack.
REQ-034 wr_req and rd_req rise same cycle after reset -> grant=01 first; after 8 words grant=10; strict alternation thereafter.
REQ-035 RD_BURST, memory never returns data -> 8 rd_ack then mem_read low, outst=8; one readdatavalid -> one more rd_ack.
REQ-036 waitrequest high for 3 cycles mid-write -> mem_write/addr/data stable, no wr_ack, burst_cnt unchanged, resumes on release.
REQ-037 Accepted read and readdatavalid same cycle at outst=5 -> outst stays 5.
REQ-038 in_reset pulse in WR_BURST word 4 -> outputs 0 immediately; after release, tie resolves to write.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared encodings and parameter defaults for the two-port SDRAM arbiter.
// Grant encodings follow the {rd,wr} bit order of the grant status port.
package sdram_arb_pkg;

    localparam int BURST_LEN_DEF = 8;
    localparam int MAX_OUTST_DEF = 8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WR_BURST = 2'd1;
    localparam logic [1:0] ST_RD_BURST = 2'd2;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_WR   = 2'b01;
    localparam logic [1:0] GNT_RD   = 2'b10;

    typedef enum logic {
        LAST_WR = 1'b0,
        LAST_RD = 1'b1
    } last_grant_e;

    function automatic logic [1:0] grant_of(input logic [1:0] state);
        case (state)
            ST_WR_BURST: return GNT_WR;
            ST_RD_BURST: return GNT_RD;
            default:     return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester, SDRAM-controller and status signals of the port arbiter.
// master = arbiter side, slave = requesters/controller/observer side.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_waitrequest;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_readdatavalid;

    logic [1:0]        grant;
    logic              busy;

    modport master (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
               mem_waitrequest, mem_readdata, mem_readdatavalid,
        output wr_ack, rd_ack, rd_data, rd_valid,
               mem_addr, mem_write, mem_read, mem_writedata, grant, busy
    );

    modport slave (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
               mem_waitrequest, mem_readdata, mem_readdatavalid,
        input  wr_ack, rd_ack, rd_data, rd_valid,
               mem_addr, mem_write, mem_read, mem_writedata, grant, busy
    );

endinterface

// File: rtl/sdram_rd_outst_cnt.sv
// Count of read words accepted by the SDRAM controller but not yet returned.
// Saturation of spurious returns is the caller's job (gate dec_i at zero).
module sdram_rd_outst_cnt
    import sdram_arb_pkg::*;
#(
    parameter int MAX_OUTST = MAX_OUTST_DEF,
    parameter int CNT_W     = $clog2(MAX_OUTST) + 1
) (
    input  logic             in_clk,
    input  logic             in_reset,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign full_o  = (count_q >= CNT_W'(MAX_OUTST));
    assign count_o = count_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between a write
// requester (image loader) and a read requester (VGA prefetch).
//
// state       | meaning
// ST_IDLE     | no owner; arbitrate on wr_req/rd_req, burst count cleared
// ST_WR_BURST | write requester drives the memory port
// ST_RD_BURST | read requester drives the memory port (throttled by outst)
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic                 in_clk,
    input  logic                 in_reset,
    sdram_port_arbiter_if.master bus
);

    localparam int BC_W  = $clog2(BURST_LEN + 1);
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    logic [1:0]        state_q, state_d;
    logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
    last_grant_e       last_q, last_d;

    logic              wr_go, rd_go, wr_acc, rd_acc, accept, own_req;
    logic              rd_full, rd_dec;
    logic [CNT_W-1:0]  outst_cnt;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    // Strobes depend on live request inputs; nothing on the requester side is latched.
    assign wr_go  = (state_q == ST_WR_BURST) && bus.wr_req;
    assign rd_go  = (state_q == ST_RD_BURST) && bus.rd_req && !rd_full;
    assign wr_acc = wr_go && !bus.mem_waitrequest;
    assign rd_acc = rd_go && !bus.mem_waitrequest;
    assign accept = wr_acc || rd_acc;

    assign own_req = (state_q == ST_WR_BURST) ? bus.wr_req : bus.rd_req;
    assign rd_dec  = bus.mem_readdatavalid && (outst_cnt != '0);

    sdram_rd_outst_cnt #(
        .MAX_OUTST (MAX_OUTST),
        .CNT_W     (CNT_W)
    ) u_outst (
        .in_clk   (in_clk),
        .in_reset (in_reset),
        .inc_i    (rd_acc),
        .dec_i    (rd_dec),
        .full_o   (rd_full),
        .count_o  (outst_cnt)
    );

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        case (state_q)
            ST_WR_BURST: begin
                addr_mux  = bus.wr_addr;
                wdata_mux = bus.wr_data;
            end
            ST_RD_BURST: addr_mux = bus.rd_addr;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        last_d      = last_q;
        case (state_q)
            ST_IDLE: begin
                burst_cnt_d = '0;
                if (bus.wr_req && bus.rd_req) begin
                    state_d = (last_q == LAST_RD) ? ST_WR_BURST : ST_RD_BURST;
                end else if (bus.wr_req) begin
                    state_d = ST_WR_BURST;
                end else if (bus.rd_req) begin
                    state_d = ST_RD_BURST;
                end
            end
            ST_WR_BURST, ST_RD_BURST: begin
                if (accept) begin
                    burst_cnt_d = burst_cnt_q + BC_W'(1);
                end
                if (!own_req || (accept && burst_cnt_q == BC_W'(BURST_LEN - 1))) begin
                    state_d     = ST_IDLE;
                    burst_cnt_d = '0;
                    last_d      = (state_q == ST_RD_BURST) ? LAST_RD : LAST_WR;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_q     <= ST_IDLE;
            burst_cnt_q <= '0;
            last_q      <= LAST_RD;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
        end
    end

    assign bus.mem_write     = wr_go;
    assign bus.mem_read      = rd_go;
    assign bus.wr_ack        = wr_acc;
    assign bus.rd_ack        = rd_acc;
    assign bus.mem_addr      = addr_mux;
    assign bus.mem_writedata = wdata_mux;
    assign bus.rd_data       = bus.mem_readdata;
    assign bus.rd_valid      = bus.mem_readdatavalid;
    assign bus.grant         = grant_of(state_q);
    assign bus.busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: per-cycle reference model compare
// plus scenario checks with hand-derived ack counts and grant sequences.
module tb_sdram_port_arbiter;

    localparam int AW = 25;
    localparam int DW = 16;
    localparam int BL = 8;
    localparam int MO = 8;

    logic in_clk   = 1'b0;
    logic in_reset = 1'b1;

    sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    sdram_port_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BURST_LEN (BL),
        .MAX_OUTST (MO)
    ) dut (
        .in_clk   (in_clk),
        .in_reset (in_reset),
        .bus      (bus)
    );

    always #5 in_clk = ~in_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: owner 0=none 1=write 2=read
    int          m_owner, m_words, m_outst;
    bit          m_last_rd;
    logic        e_w, e_r, e_wa, e_ra, m_dec, m_req;
    logic [1:0]  e_grant;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    initial begin
        m_owner = 0; m_words = 0; m_outst = 0; m_last_rd = 1'b1;
        forever begin
            @(negedge in_clk);
            if (in_reset) begin
                m_owner = 0; m_words = 0; m_outst = 0; m_last_rd = 1'b1;
            end
            e_w  = (m_owner == 1) && bus.wr_req;
            e_r  = (m_owner == 2) && bus.rd_req && (m_outst < MO);
            e_wa = e_w && !bus.mem_waitrequest;
            e_ra = e_r && !bus.mem_waitrequest;
            e_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
            e_addr  = '0;
            e_wdata = '0;
            if (m_owner == 1) begin
                e_addr  = bus.wr_addr;
                e_wdata = bus.wr_data;
            end else if (m_owner == 2) begin
                e_addr = bus.rd_addr;
            end
            chk("mem_write", bus.mem_write, e_w);
            chk("mem_read", bus.mem_read, e_r);
            chk("wr_ack", bus.wr_ack, e_wa);
            chk("rd_ack", bus.rd_ack, e_ra);
            chk("grant", bus.grant, e_grant);
            chk("busy", bus.busy, m_owner != 0);
            chk("mem_addr", bus.mem_addr, e_addr);
            if (m_owner != 2) chk("mem_writedata", bus.mem_writedata, e_wdata);
            chk("rd_data", bus.rd_data, bus.mem_readdata);
            chk("rd_valid", bus.rd_valid, bus.mem_readdatavalid);
            if (!in_reset) begin
                m_dec = bus.mem_readdatavalid && (m_outst > 0);
                if (e_ra && !m_dec) m_outst++;
                else if (m_dec && !e_ra) m_outst--;
                if (m_owner == 0) begin
                    if (bus.wr_req && bus.rd_req) m_owner = m_last_rd ? 1 : 2;
                    else if (bus.wr_req) m_owner = 1;
                    else if (bus.rd_req) m_owner = 2;
                    m_words = 0;
                end else begin
                    m_req = (m_owner == 1) ? bus.wr_req : bus.rd_req;
                    if (e_wa || e_ra) m_words++;
                    if (!m_req || m_words == BL) begin
                        m_last_rd = (m_owner == 2);
                        m_owner = 0;
                        m_words = 0;
                    end
                end
            end
        end
    end

    // Memory side: read data returns a fixed number of cycles after each accepted read
    bit mem_auto = 1'b0;
    bit rdv_dir  = 1'b0;
    bit p0 = 1'b0, p1 = 1'b0, racked = 1'b0;

    initial begin
        bus.mem_readdatavalid = 1'b0;
        bus.mem_readdata      = '0;
        forever begin
            @(negedge in_clk);
            racked = bus.rd_ack;
            @(posedge in_clk);
            #2;
            bus.mem_readdatavalid = mem_auto ? p1 : rdv_dir;
            p1 = p0;
            p0 = racked;
            bus.mem_readdata = DW'($urandom);
        end
    end

    int n_wack, n_rack;
    logic s_wack, s_rack, s_mread, s_mwrite, s_busy, s_rvalid;
    logic [1:0] s_grant;
    logic [AW-1:0] s_maddr, saved_addr;

    task automatic step();
        @(negedge in_clk);
        #1;
        s_wack   = bus.wr_ack;
        s_rack   = bus.rd_ack;
        s_mread  = bus.mem_read;
        s_mwrite = bus.mem_write;
        s_busy   = bus.busy;
        s_rvalid = bus.rd_valid;
        s_grant  = bus.grant;
        s_maddr  = bus.mem_addr;
        n_wack  += int'(s_wack);
        n_rack  += int'(s_rack);
        @(posedge in_clk);
        #1;
        if (s_wack) begin
            bus.wr_addr = AW'($urandom);
            bus.wr_data = DW'($urandom);
        end
        if (s_rack) bus.rd_addr = AW'($urandom);
    endtask

    task automatic do_reset();
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        in_reset = 1'b1;
        step();
        step();
        in_reset = 1'b0;
    endtask

    initial begin
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        bus.wr_addr = AW'($urandom);
        bus.wr_data = DW'($urandom);
        bus.rd_addr = AW'($urandom);
        bus.mem_waitrequest = 1'b0;
        step();
        step();
        in_reset = 1'b0;
        step();

        // back-to-back write bursts
        bus.wr_req = 1'b1;
        n_wack = 0;
        for (int i = 0; i < 18; i++) begin
            step();
            if (i == 0) chk("A first grant", s_grant, 2'b00);
            if (i == 1) chk("A wr grant", s_grant, 2'b01);
            if (i == 9) begin
                chk("A gap busy", s_busy, 1'b0);
                chk("A gap ack", s_wack, 1'b0);
            end
        end
        chk("A ack count", n_wack, 16);
        bus.wr_req = 1'b0;
        step();

        // simultaneous requests: strict alternation, write first after reset
        do_reset();
        mem_auto = 1'b1;
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        n_wack = 0;
        n_rack = 0;
        for (int i = 0; i < 36; i++) begin
            int ph;
            logic [1:0] eg;
            step();
            ph = i % 18;
            eg = (ph == 0 || ph == 9) ? 2'b00 : (ph < 9) ? 2'b01 : 2'b10;
            chk("B grant seq", s_grant, eg);
        end
        chk("B wr acks", n_wack, 16);
        chk("B rd acks", n_rack, 16);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        repeat (6) step();
        mem_auto = 1'b0;

        // no read data returned: stall at MAX_OUTST, one return frees one slot
        do_reset();
        bus.rd_req = 1'b1;
        n_rack = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (i == 11) begin
                chk("C stall read", s_mread, 1'b0);
                chk("C stall busy", s_busy, 1'b1);
                chk("C stall grant", s_grant, 2'b10);
            end
        end
        chk("C ack count", n_rack, 8);
        rdv_dir = 1'b1;
        step();
        chk("C rd_valid", s_rvalid, 1'b1);
        rdv_dir = 1'b0;
        step();
        chk("C extra ack", s_rack, 1'b1);
        step();
        chk("C restall", s_mread, 1'b0);
        chk("C total acks", n_rack, 9);
        bus.rd_req = 1'b0;
        step();
        step();

        // spurious return at zero outstanding is forwarded and does not wrap
        do_reset();
        rdv_dir = 1'b1;
        step();
        chk("D idle rd_valid", s_rvalid, 1'b1);
        rdv_dir = 1'b0;
        step();
        bus.rd_req = 1'b1;
        n_rack = 0;
        repeat (10) step();
        chk("D ack count", n_rack, 8);
        bus.rd_req = 1'b0;
        step();

        // accept and return in the same cycle at 5 outstanding
        do_reset();
        bus.rd_req = 1'b1;
        n_rack = 0;
        repeat (6) step();
        chk("E first acks", n_rack, 5);
        bus.rd_req = 1'b0;
        step();
        bus.rd_req = 1'b1;
        step();
        n_rack = 0;
        rdv_dir = 1'b1;
        step();
        chk("E same-cycle ack", s_rack, 1'b1);
        chk("E same-cycle valid", s_rvalid, 1'b1);
        rdv_dir = 1'b0;
        repeat (7) step();
        chk("E burst acks", n_rack, 4);
        bus.rd_req = 1'b0;
        step();
        step();

        // waitrequest stall in the middle of a write burst
        do_reset();
        bus.wr_req = 1'b1;
        n_wack = 0;
        repeat (3) step();
        bus.mem_waitrequest = 1'b1;
        saved_addr = bus.wr_addr;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("F stall ack", s_wack, 1'b0);
            chk("F stall write", s_mwrite, 1'b1);
            chk("F stall addr", s_maddr, saved_addr);
        end
        bus.mem_waitrequest = 1'b0;
        repeat (6) step();
        chk("F last ack", s_wack, 1'b1);
        bus.wr_req = 1'b0;
        step();
        chk("F end idle", s_busy, 1'b0);
        chk("F ack count", n_wack, 8);

        // reset during the fourth write word; tie afterwards goes to write
        bus.wr_req = 1'b1;
        repeat (4) step();
        chk("G pre grant", s_grant, 2'b01);
        #2;
        in_reset = 1'b1;
        #1;
        chk("G rst write", bus.mem_write, 1'b0);
        chk("G rst ack", bus.wr_ack, 1'b0);
        chk("G rst busy", bus.busy, 1'b0);
        chk("G rst grant", bus.grant, 2'b00);
        bus.rd_req = 1'b1;
        step();
        step();
        in_reset = 1'b0;
        step();
        step();
        chk("G tie grant", s_grant, 2'b01);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
